// File: rtl/fp_root_sched_if.sv
// Bundle of request, engine and response signals for fp_root_sched.
// The slave modport is the scheduler's view; master is the environment's
// view (requesters, engine model, response sink).
interface fp_root_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic                 eng_start;
  logic [31:0]          eng_a;
  logic [31:0]          eng_b;
  logic                 eng_done;
  logic [31:0]          eng_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, eng_done, eng_result, rsp_ready,
    output req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, eng_done, eng_result, rsp_ready,
    input  req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/fp_root_sched.sv
// Round-robin scheduler sharing one multi-cycle FP32 nth-root engine
// (a^(1/b)) between NREQ requesters. Special operands are answered locally
// without touching the engine. Optional WAIT watchdog: ROOT_TIMEOUT_EN.
module fp_root_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TMO_CYC = 255
) (
  input logic            clk,
  input logic            rst_n,
  fp_root_sched_if.slave bus
);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TMO_CYC < 1) begin : g_param_check
    $error("fp_root_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StGrant, StIssue, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [31:0]    data_q, data_d;
  logic           err_q, err_d;

  logic [NREQ-1:0] req_ready;
  logic            eng_start;
  logic            rsp_valid;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic [31:0]    win_a, win_b;
  logic           special;
  logic [31:0]    special_val;

`ifdef ROOT_TIMEOUT_EN
  localparam int unsigned TmoW = (TMO_CYC > 255) ? $clog2(TMO_CYC + 1) : 8;
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  // Round-robin search: first valid requester above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % int'(NREQ));
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_a = bus.req_a[32*int'(win) +: 32];
  assign win_b = bus.req_b[32*int'(win) +: 32];

  // Classify the operands being latched; first matching rule wins.
  always_comb begin
    logic a_nan, b_nan, b_zero, a_pinf, a_neg, a_zero;
    a_nan  = (win_a[30:23] == 8'hFF) && (win_a[22:0] != '0);
    b_nan  = (win_b[30:23] == 8'hFF) && (win_b[22:0] != '0);
    b_zero = (win_b[30:0] == '0);
    a_pinf = (win_a == 32'h7F80_0000);
    a_zero = (win_a[30:0] == '0);
    a_neg  = win_a[31] && !a_zero;
    special     = 1'b1;
    special_val = 32'h7FFF_FFFF;
    if (a_nan || b_nan) begin
      special_val = 32'h7FFF_FFFF;
    end else if (b_zero) begin
      special_val = 32'h7FFF_FFFF;
    end else if (a_pinf) begin
      special_val = 32'h7F80_0000;
    end else if (a_neg) begin
      special_val = 32'h7FFF_FFFF;
    end else if (a_zero) begin
      special_val = 32'h0000_0000;
    end else begin
      special = 1'b0;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    eng_start = 1'b0;
    rsp_valid = 1'b0;
`ifdef ROOT_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) state_d = StGrant;
      end
      StGrant: begin
        if (found) begin
          req_ready[win] = 1'b1;
          rr_ptr_d       = win;
          id_d           = win;
          a_d            = win_a;
          b_d            = win_b;
          if (special) begin
            data_d  = special_val;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end else begin
          // Requests withdrawn between IDLE and GRANT.
          state_d = StIdle;
        end
      end
      StIssue: begin
        eng_start = 1'b1;
        state_d   = StWait;
`ifdef ROOT_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      StWait: begin
        if (bus.eng_done) begin
          data_d  = bus.eng_result;
          err_d   = 1'b0;
          state_d = StResp;
        end
`ifdef ROOT_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TmoW'(TMO_CYC - 1)) begin
            data_d  = 32'h7FFF_FFFF;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
`endif
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and job registers; reset drops any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= IDW'(NREQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

`ifdef ROOT_TIMEOUT_EN
  // Watchdog counter for the WAIT state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // Operands stay on the engine bus from ISSUE through WAIT.
  assign bus.req_ready = req_ready;
  assign bus.eng_start = eng_start;
  assign bus.eng_a     = a_q;
  assign bus.eng_b     = b_q;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fp_root_sched.sv
// Directed bench for fp_root_sched: engine job, special cases, round-robin,
// response backpressure, asynchronous reset mid-job, optional watchdog.
module tb_fp_root_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fp_root_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fp_root_sched #(.NREQ(NREQ), .IDW(IDW), .TMO_CYC(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Engine model: done arrives eng_lat WAIT cycles after the first WAIT cycle.
  logic        eng_en = 1'b0;
  int          eng_lat = 5;
  logic [31:0] eng_res = '0;
  logic        mdl_done = 1'b0;
  logic        man_done = 1'b0;
  assign bus.eng_done   = mdl_done | man_done;
  assign bus.eng_result = eng_res;

  always begin
    @(negedge clk);
    if (bus.eng_start && eng_en) begin
      repeat (eng_lat + 1) @(posedge clk);
      #1 mdl_done = 1'b1;
      @(posedge clk);
      #1 mdl_done = 1'b0;
    end
  end

  int          n_start = 0;
  logic [31:0] cap_a = '0;
  logic [31:0] cap_b = '0;
  always @(negedge clk) begin
    if (bus.eng_start) begin
      n_start <= n_start + 1;
      cap_a   <= bus.eng_a;
      cap_b   <= bus.eng_b;
    end
  end

  // Request from one requester on an idle DUT; returns cycles GRANT -> rsp_valid.
  task automatic do_req(input int r, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(posedge clk);
    #1;
    bus.req_a[r*32 +: 32] = a;
    bus.req_b[r*32 +: 32] = b;
    bus.req_valid[r] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("grant_ready", 32'(bus.req_ready), 32'd1 << r);
    @(posedge clk);
    #1 bus.req_valid[r] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 200);
    if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {22'd0, bus.req_ready, bus.eng_start, bus.rsp_valid, bus.busy,
                          bus.rsp_err, bus.rsp_id}, 32'd0);
    check({tag, "_eng_a"}, bus.eng_a, 32'd0);
    check({tag, "_eng_b"}, bus.eng_b, 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
  endtask

  logic [31:0] sp_a [3] = '{32'hC080_0000, 32'h7F80_0000, 32'h4080_0000};
  logic [31:0] sp_b [3] = '{32'h4000_0000, 32'h4000_0000, 32'h0000_0000};
  logic [31:0] sp_r [3] = '{32'h7FFF_FFFF, 32'h7F80_0000, 32'h7FFF_FFFF};

  initial begin
    int lat;
    int s0;
    int gi;
    int cyc;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    #2 check_reset("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic engine job: 8^(1/3) = 2.
    eng_en  = 1'b1;
    eng_lat = 5;
    eng_res = 32'h4000_0000;
    s0 = n_start;
    do_req(0, 32'h4100_0000, 32'h4040_0000, lat);
    check("eng_lat", 32'(lat), 32'd8);
    check("eng_id", 32'(bus.rsp_id), 32'd0);
    check("eng_data", bus.rsp_data, 32'h4000_0000);
    check("eng_err", 32'(bus.rsp_err), 32'd0);
    check("eng_starts", 32'(n_start - s0), 32'd1);
    check("eng_a", cap_a, 32'h4100_0000);
    check("eng_b", cap_b, 32'h4040_0000);
    check("eng_a_held", bus.eng_a, 32'h4100_0000);
    eng_en = 1'b0;

    // Special cases on requesters 1..3: no engine start, 1-cycle latency.
    for (int i = 0; i < 3; i++) begin
      s0 = n_start;
      do_req(i + 1, sp_a[i], sp_b[i], lat);
      check("sp_lat", 32'(lat), 32'd1);
      check("sp_id", 32'(bus.rsp_id), 32'(i + 1));
      check("sp_data", bus.rsp_data, sp_r[i]);
      check("sp_err", 32'(bus.rsp_err), 32'd1);
      check("sp_nostart", 32'(n_start - s0), 32'd0);
    end

    // Round-robin with all requesters asserting (a=0 -> local answer).
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*32 +: 32] = 32'h0;
      bus.req_b[i*32 +: 32] = 32'h4000_0000;
    end
    bus.req_valid = 4'hF;
    gi = 0;
    cyc = 0;
    while (gi < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready != '0) begin
        check("rr_grant", 32'(bus.req_ready), 32'd1 << (gi % 4));
        gi++;
        @(negedge clk);
        check("rr_pulse", 32'(bus.req_ready), 32'd0);
        check("rr_data", bus.rsp_data, 32'd0);
      end
    end
    if (gi < 5) check("rr_count", 32'(gi), 32'd5);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (3) @(negedge clk);
    check("rr_idle", 32'(bus.busy), 32'd0);

    // Backpressure: rsp_ready low for 10 cycles while requester 1 waits.
    bus.rsp_ready = 1'b0;
    do_req(2, 32'hC080_0000, 32'h4000_0000, lat);
    bus.req_a[32 +: 32] = 32'h0;
    bus.req_b[32 +: 32] = 32'h4000_0000;
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_ctl", {25'd0, bus.busy, bus.rsp_valid, bus.rsp_err, bus.rsp_id, 1'b0,
                       bus.eng_start}, {25'd0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0});
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      check("bp_data", bus.rsp_data, 32'h7FFF_FFFF);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    cyc = 0;
    while (bus.req_ready[1] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_next_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("bp_next_id", 32'(bus.rsp_id), 32'd1);
    check("bp_next_valid", 32'(bus.rsp_valid), 32'd1);

    // Reset during WAIT: job dropped, late done ignored, rr_ptr restored.
    @(posedge clk);
    #1;
    bus.req_a[31:0] = 32'h4100_0000;
    bus.req_b[31:0] = 32'h4040_0000;
    bus.req_valid[0] = 1'b1;
    cyc = 0;
    while (bus.req_ready[0] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_busy", 32'(bus.busy), 32'd1);
    check("wait_eng_a", bus.eng_a, 32'h4100_0000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {30'd0, bus.rsp_valid, bus.busy}, 32'd0);
    end
    @(posedge clk);
    #1 bus.req_valid = 4'hF;
    cyc = 0;
    while (bus.req_ready == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("post_reset_first", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(negedge clk);

`ifdef ROOT_TIMEOUT_EN
    // Watchdog: 20 WAIT cycles without done.
    eng_en = 1'b0;
    do_req(3, 32'h4100_0000, 32'h4040_0000, lat);
    check("tmo_lat", 32'(lat), 32'd22);
    check("tmo_data", bus.rsp_data, 32'h7FFF_FFFF);
    check("tmo_err", 32'(bus.rsp_err), 32'd1);
    check("tmo_id", 32'(bus.rsp_id), 32'd3);
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("tmo_late_done", {30'd0, bus.rsp_valid, bus.busy}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

endmodule

// File: doc/fp_root_sched.md
Name: fp_root_sched

Overview:
- Round-robin scheduler that shares one multi-cycle single-precision (IEEE-754) nth-root engine between NREQ requesters.
- The engine computes a^(1/b) through its reciprocal and power stages.
- The block screens operands for special cases and answers those locally, bypassing the engine.
- It issues one job at a time to the engine and returns each result to its requester, tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester id; must satisfy 2^IDW >= NREQ.
- TMO_CYC, 255, watchdog limit in cycles (used only with ROOT_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  32*NREQ  base operand, slice i belongs to requester i.
- req_b  in  32*NREQ  root operand, slice i belongs to requester i.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a  out  32  base operand to the engine.
- eng_b  out  32  root operand to the engine.
- eng_done  in  1  one-cycle engine completion pulse.
- eng_result  in  32  engine result; valid while eng_done=1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  32  result word.
- rsp_err  out  1  1 = the result came from the special-case path or a timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=NREQ-1, req_ready=0, eng_start=0, eng_a=0, eng_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
- Reset is asynchronous and may assert at any time, including mid-job. The job is dropped and no response is produced.
- FSM states: IDLE, GRANT, ISSUE, WAIT, RESP.
- IDLE: if any req_valid bit is set, go to GRANT.
- GRANT:
  - Winner is the first set req_valid bit searching upward from rr_ptr+1, wrapping modulo NREQ.
  - req_ready[winner]=1 for exactly this cycle; the handshake completes here.
  - Latch the winner's a and b and the winner index; set rr_ptr=winner.
  - If req_valid has dropped to all zero, return to IDLE with no grant.
- Special-case classification, on the latched operands (NaN = exponent 0xFF with nonzero mantissa):
  - a NaN or b NaN -> 0x7FFFFFFF.
  - b = +/-0 -> 0x7FFFFFFF.
  - a = +inf -> 0x7F800000.
  - a negative and nonzero -> 0x7FFFFFFF.
  - a = +/-0 -> 0x00000000.
  - The first matching rule in the order above wins.
  - On a match: go straight to RESP with rsp_err=1.
  - Otherwise: go to ISSUE.
- ISSUE: eng_start=1 for one cycle, eng_a and eng_b driven from the latched operands; next state WAIT.
- WAIT:
  - eng_a and eng_b are held stable.
  - On eng_done: capture eng_result into rsp_data, set rsp_err=0, go to RESP.
  - An eng_done pulse seen in any state other than WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE. One idle cycle follows every job.
- Minimum latencies, counted from the GRANT cycle to the first rsp_valid:
  - special case: 1 cycle.
  - engine path: 3 + engine latency.
- Never more than one job is outstanding. Requests are never dropped; a requester holds req_valid until it sees req_ready.
- Fairness: a requester that holds req_valid waits at most NREQ-1 other jobs before it is granted.

Optional Feature:
- Macro: ROOT_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TMO_CYC without eng_done: go to RESP with rsp_data=0x7FFFFFFF and rsp_err=1.
  - A late eng_done is then ignored.
- Without the macro: no counter; WAIT waits for eng_done indefinitely.

Test Plan:
- Basic engine job: requester 0 sends a=0x41000000 (8.0), b=0x40400000 (3.0); engine model returns 0x40000000 after 5 cycles -> eng_a/eng_b carry those operands, rsp_id=0, rsp_data=0x40000000, rsp_err=0, and the response appears 8 cycles after GRANT.
- Special cases, each with no eng_start pulse and rsp_err=1:
  - a=0xC0800000 (negative), b=0x40000000 -> 0x7FFFFFFF.
  - a=0x7F800000 (+inf), b=0x40000000 -> 0x7F800000.
  - a=0x40800000, b=0x00000000 -> 0x7FFFFFFF.
- Round-robin: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each req_ready is a single-cycle one-hot pulse.
- Response backpressure: rsp_ready held at 0 for 10 cycles in RESP -> rsp_* stay stable, no new grant occurs, busy=1 throughout.
- Reset mid-job: rst_n driven low during WAIT -> all outputs return to reset values immediately; after release, an eng_done pulse produces no response.
- With ROOT_TIMEOUT_EN and TMO_CYC=20, engine never pulses done -> after 20 WAIT cycles, rsp_data=0x7FFFFFFF and rsp_err=1.
